// File: rtl/vmac_sequencer.sv
// Job-batch sequencer for a vector MAC: fetches a/b/c operand words per job from
// a word-addressed memory, waits for the MAC pipeline, and writes the result back.
module vmac_sequencer #(
    parameter int VLEN    = 48,
    parameter int ADDR_W  = 8,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_jobs,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [VLEN-1:0]   mem_wdata,
    input  logic [VLEN-1:0]   mem_rdata,
    output logic [VLEN-1:0]   a_vec,
    output logic [VLEN-1:0]   b_vec,
    output logic [VLEN-1:0]   c_vec,
    input  logic [VLEN-1:0]   mac_out
);

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_CAPT, S_WAIT, S_WR, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   num_q, num_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [VLEN-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ADDR_W-1:0]   job_addr;
    logic [ADDR_W-1:0]   last_k;

    // Job word J = base + 4k; the sum wraps naturally at ADDR_W bits.
    assign job_addr = base_q + {k_q[ADDR_W-3:0], 2'b00};
    assign last_k   = num_q - ADDR_W'(1);

    assign a_vec = a_q;
    assign b_vec = b_q;
    assign c_vec = c_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_jobs;
                    k_d     = '0;
                    state_d = (num_jobs == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                mem_en   = 1'b1;
                mem_addr = job_addr;
                state_d  = S_RD_B;
            end
            // Read data lags the address by one cycle, so each state captures
            // the word requested by the previous one.
            S_RD_B: begin
                mem_en   = 1'b1;
                mem_addr = job_addr + ADDR_W'(1);
                a_d      = mem_rdata;
                state_d  = S_RD_C;
            end
            S_RD_C: begin
                mem_en   = 1'b1;
                mem_addr = job_addr + ADDR_W'(2);
                b_d      = mem_rdata;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                c_d     = mem_rdata;
                cnt_d   = CNT_W'(MAC_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = job_addr + ADDR_W'(3);
                mem_wdata = mac_out;
                if (k_q == last_k) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + ADDR_W'(1);
                    state_d = S_RD_A;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
